// File: rtl/v1_pulse_gen_pkg.sv
// v1_pulse_gen_pkg: shared settings for the synthetic pulse source.
//   SIZE_ADC_DATA      : ADC sample width in bits
//   PG_*               : default shape parameters for v1_pulse_gen
//   pg_state_t         : pulse generator state encoding
//   lfsr16_feedback()  : feedback bit of the 16-bit noise LFSR (taps 16,14,13,11)
package v1_pulse_gen_pkg;

  localparam int unsigned SIZE_ADC_DATA  = 14;

  localparam int unsigned PG_RISE_SHIFT  = 2;
  localparam int unsigned PG_DECAY_SHIFT = 4;
  localparam int unsigned PG_FRAC_BITS   = 8;
  localparam int unsigned PG_BASELINE    = 0;

  localparam logic [15:0] PG_LFSR_SEED   = 16'hACE1;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_RISE,
    PG_DECAY
  } pg_state_t;

  // Fibonacci feedback for polynomial x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic lfsr16_feedback(input logic [15:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

endpackage

// File: rtl/v1_pulse_gen_lfsr16.sv
// v1_lfsr16: 16-bit Fibonacci LFSR supplying output dither for v1_pulse_gen.
// Only present when V1_PULSE_GEN_NOISE_EN is defined.
// Ports:
//   clk       : system clock
//   reset     : asynchronous reset, active-low (loads seed 16'hACE1)
//   seed_load : reload the seed on the next edge
//   noise     : low 3 bits of the register, read as signed -4..+3 by the user
`ifdef V1_PULSE_GEN_NOISE_EN
module v1_lfsr16
  import v1_pulse_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       seed_load,
  output logic [2:0] noise
);

  logic [15:0] lfsr_q;

  // Shift left, new bit enters at the bottom.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= PG_LFSR_SEED;
    end else if (seed_load) begin
      lfsr_q <= PG_LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr16_feedback(lfsr_q)};
    end
  end

  assign noise = lfsr_q[2:0];

endmodule
`endif

// File: rtl/v1_pulse_gen.sv
// v1_pulse_gen: synthetic detector-pulse source producing ADC-format samples.
// Each accepted trigger yields a linear rise over 2^RISE_SHIFT cycles to the
// programmed amplitude, then an exponential decay acc -= acc >> DECAY_SHIFT.
// A trigger during decay stacks a new rise on the residual (pile-up).
// Optional macro V1_PULSE_GEN_NOISE_EN adds LFSR dither (-4..+3 codes) and
// the noise_seed_load input.
// Ports:
//   clk             : system clock
//   reset           : asynchronous reset, active-low
//   noise_seed_load : (noise build only) reload LFSR seed
//   trig            : pulse request, sampled on rising clk
//   amplitude       : pulse height in ADC codes, sampled with trig
//   trig_ready      : a trigger would be accepted this cycle
//   busy            : state is not IDLE
//   output_data     : registered sample stream, one sample per clk
//   pulse_count     : accepted triggers, wraps modulo 2^16
module v1_pulse_gen
  import v1_pulse_gen_pkg::*;
#(
  parameter int unsigned RISE_SHIFT  = PG_RISE_SHIFT,
  parameter int unsigned DECAY_SHIFT = PG_DECAY_SHIFT,
  parameter int unsigned FRAC_BITS   = PG_FRAC_BITS,
  parameter int unsigned BASELINE    = PG_BASELINE
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef V1_PULSE_GEN_NOISE_EN
  input  logic                     noise_seed_load,
`endif
  input  logic                     trig,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  output logic                     trig_ready,
  output logic                     busy,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic [15:0]              pulse_count
);

  localparam int unsigned ACC_W = SIZE_ADC_DATA + FRAC_BITS;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = RISE_SHIFT + 1;

  localparam logic [ACC_W-1:0] ACC_MAX =
    ACC_W'(((64'(1) << SIZE_ADC_DATA) - 64'(1)) << FRAC_BITS);
  localparam logic [CNT_W-1:0] RISE_LEN = CNT_W'(64'(1) << RISE_SHIFT);
  localparam int               OUT_MAX  = (1 << SIZE_ADC_DATA) - 1;

  pg_state_t        state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] step_q;
  logic [CNT_W-1:0] cnt_q;

  pg_state_t        state_n;
  logic [ACC_W-1:0] acc_n;
  logic [ACC_W-1:0] step_n;
  logic [CNT_W-1:0] cnt_n;
  logic [15:0]      count_n;

  logic                     accept_c;
  logic [ACC_W-1:0]         amp_scaled_c;
  logic [ACC_W-1:0]         step_new_c;
  logic [ACC_W-1:0]         add_src_c;
  logic [SUM_W-1:0]         sum_c;
  logic [ACC_W-1:0]         acc_add_c;
  logic [ACC_W-1:0]         decay_c;
  logic [ACC_W-1:0]         acc_dec_c;
  logic [CNT_W-1:0]         cnt_inc_c;
  logic [SIZE_ADC_DATA-1:0] int_part_c;
  logic signed [31:0]       out_sum_c;
  logic [SIZE_ADC_DATA-1:0] out_c;

`ifdef V1_PULSE_GEN_NOISE_EN
  logic [2:0] noise_c;

  v1_lfsr16 u_lfsr16 (
    .clk       (clk),
    .reset     (reset),
    .seed_load (noise_seed_load),
    .noise     (noise_c)
  );
`endif

  assign accept_c = trig && trig_ready;

  // Per-cycle rise increment in accumulator units.
  assign amp_scaled_c = ACC_W'(amplitude) << FRAC_BITS;
  assign step_new_c   = amp_scaled_c >> RISE_SHIFT;

  // Saturating add; a new trigger uses its own step, otherwise the latched one.
  assign add_src_c = accept_c ? step_new_c : step_q;
  assign sum_c     = SUM_W'(acc_q) + SUM_W'(add_src_c);
  assign acc_add_c = (sum_c > SUM_W'(ACC_MAX)) ? ACC_MAX : sum_c[ACC_W-1:0];

  assign decay_c   = acc_q >> DECAY_SHIFT;
  assign acc_dec_c = acc_q - decay_c;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state and accumulator update.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    step_n  = step_q;
    cnt_n   = cnt_q;
    count_n = pulse_count;
    case (state_q)
      PG_IDLE: begin
        if (accept_c) begin
          acc_n   = acc_add_c;
          step_n  = step_new_c;
          cnt_n   = CNT_W'(1);
          count_n = pulse_count + 16'd1;
          state_n = (RISE_LEN == CNT_W'(1)) ? PG_DECAY : PG_RISE;
        end
      end
      PG_RISE: begin
        acc_n = acc_add_c;
        cnt_n = cnt_inc_c;
        if (cnt_inc_c == RISE_LEN) begin
          state_n = PG_DECAY;
        end
      end
      PG_DECAY: begin
        if (accept_c) begin
          // Pile-up: the new rise starts from the residual instead of decaying.
          acc_n   = acc_add_c;
          step_n  = step_new_c;
          cnt_n   = CNT_W'(1);
          count_n = pulse_count + 16'd1;
          state_n = (RISE_LEN == CNT_W'(1)) ? PG_DECAY : PG_RISE;
        end else if ((decay_c == '0) ||
                     (acc_dec_c[ACC_W-1:FRAC_BITS] == '0)) begin
          acc_n   = '0;
          state_n = PG_IDLE;
        end else begin
          acc_n = acc_dec_c;
        end
      end
      default: begin
        acc_n   = '0;
        cnt_n   = '0;
        state_n = PG_IDLE;
      end
    endcase
  end

  // Output sample follows the new accumulator value on the same edge.
  assign int_part_c = acc_n[ACC_W-1:FRAC_BITS];
`ifdef V1_PULSE_GEN_NOISE_EN
  assign out_sum_c = 32'(int_part_c) + 32'(BASELINE) + 32'($signed(noise_c));
`else
  assign out_sum_c = 32'(int_part_c) + 32'(BASELINE);
`endif

  always_comb begin
    out_c = out_sum_c[SIZE_ADC_DATA-1:0];
    if (out_sum_c < 32'sd0) begin
      out_c = '0;
    end else if (out_sum_c > OUT_MAX) begin
      out_c = SIZE_ADC_DATA'(OUT_MAX);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= PG_IDLE;
      acc_q       <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      output_data <= '0;
      pulse_count <= '0;
      busy        <= 1'b0;
      trig_ready  <= 1'b0;
    end else begin
      state_q     <= state_n;
      acc_q       <= acc_n;
      step_q      <= step_n;
      cnt_q       <= cnt_n;
      output_data <= out_c;
      pulse_count <= count_n;
      busy        <= (state_n != PG_IDLE);
      trig_ready  <= (state_n != PG_RISE);
    end
  end

endmodule

// File: tb/tb_v1_pulse_gen.sv
// tb_v1_pulse_gen: directed self-checking bench for v1_pulse_gen (noise off).
// dut uses BASELINE=0; dut_sat uses BASELINE=100 for the saturation case.
module tb_v1_pulse_gen;

  logic        clk;
  logic        reset;
  logic        trig;
  logic [13:0] amp;
  logic        trig_ready;
  logic        busy;
  logic [13:0] out;
  logic [15:0] pcount;

  logic        sat_trig;
  logic [13:0] sat_amp;
  logic        sat_ready;
  logic        sat_busy;
  logic [13:0] sat_out;
  logic [15:0] sat_pcount;

  int checks = 0;
  int errors = 0;

  v1_pulse_gen dut (
    .clk         (clk),
    .reset       (reset),
`ifdef V1_PULSE_GEN_NOISE_EN
    .noise_seed_load (1'b0),
`endif
    .trig        (trig),
    .amplitude   (amp),
    .trig_ready  (trig_ready),
    .busy        (busy),
    .output_data (out),
    .pulse_count (pcount)
  );

  v1_pulse_gen #(.BASELINE(100)) dut_sat (
    .clk         (clk),
    .reset       (reset),
`ifdef V1_PULSE_GEN_NOISE_EN
    .noise_seed_load (1'b0),
`endif
    .trig        (sat_trig),
    .amplitude   (sat_amp),
    .trig_ready  (sat_ready),
    .busy        (sat_busy),
    .output_data (sat_out),
    .pulse_count (sat_pcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Follow the decay from accumulator value acc0 until the pulse ends.
  task automatic decay_to_idle(input string tag, input int unsigned acc0);
    int unsigned m;
    bit done;
    m = acc0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      int unsigned d;
      int unsigned n;
      d = m >> 4;
      n = m - d;
      if (d == 0 || (n >> 8) == 0) n = 0;
      m = n;
      step();
      check(tag, 32'(out), n >> 8);
      if (n == 0) begin
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ready"}, 32'(trig_ready), 1);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    trig     = 1'b0;
    amp      = '0;
    sat_trig = 1'b0;
    sat_amp  = '0;

    // Reset values, asserted asynchronously.
    #2 reset = 1'b0;
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(trig_ready), 0);
    check("rst_count", 32'(pcount), 0);
    step();
    step();
    check("rst_hold_ready", 32'(trig_ready), 0);
    #2 reset = 1'b1;
    step();
    check("rel_out", 32'(out), 0);
    check("rel_ready", 32'(trig_ready), 1);
    check("rel_busy", 32'(busy), 0);
    check("rel_sat_out", 32'(sat_out), 100);

    // Single pulse, amplitude 1000.
    trig = 1'b1;
    amp  = 14'd1000;
    step();
    trig = 1'b0;
    check("sp_r1", 32'(out), 250);
    check("sp_busy", 32'(busy), 1);
    check("sp_ready_rise", 32'(trig_ready), 0);
    check("sp_count", 32'(pcount), 1);
    step();
    check("sp_r2", 32'(out), 500);
    step();
    check("sp_r3", 32'(out), 750);
    step();
    check("sp_r4", 32'(out), 1000);
    check("sp_ready_decay", 32'(trig_ready), 1);
    decay_to_idle("sp_decay", 256000);
    check("sp_count_end", 32'(pcount), 1);

    // Trigger two cycles into RISE is dropped.
    trig = 1'b1;
    amp  = 14'd1000;
    step();
    trig = 1'b0;
    check("ri_r1", 32'(out), 250);
    step();
    check("ri_r2", 32'(out), 500);
    check("ri_ready", 32'(trig_ready), 0);
    trig = 1'b1;
    amp  = 14'd400;
    step();
    trig = 1'b0;
    check("ri_r3", 32'(out), 750);
    check("ri_count", 32'(pcount), 2);
    step();
    check("ri_r4", 32'(out), 1000);
    decay_to_idle("ri_decay", 256000);
    check("ri_count_end", 32'(pcount), 2);

    // Pile-up on the 937 sample.
    trig = 1'b1;
    amp  = 14'd1000;
    step();
    trig = 1'b0;
    step();
    step();
    step();
    check("pu_peak", 32'(out), 1000);
    step();
    check("pu_937", 32'(out), 937);
    trig = 1'b1;
    amp  = 14'd400;
    step();
    trig = 1'b0;
    check("pu_s1", 32'(out), 1037);
    check("pu_count", 32'(pcount), 4);
    check("pu_ready", 32'(trig_ready), 0);
    step();
    check("pu_s2", 32'(out), 1137);
    step();
    check("pu_s3", 32'(out), 1237);
    step();
    check("pu_s4", 32'(out), 1337);
    check("pu_ready_decay", 32'(trig_ready), 1);
    decay_to_idle("pu_decay", 342400);

    // Zero amplitude still runs a full rise and is counted.
    trig = 1'b1;
    amp  = 14'd0;
    step();
    trig = 1'b0;
    check("z_out", 32'(out), 0);
    check("z_busy", 32'(busy), 1);
    check("z_count", 32'(pcount), 5);
    step();
    step();
    step();
    check("z_busy_r4", 32'(busy), 1);
    check("z_ready_r4", 32'(trig_ready), 1);
    step();
    check("z_busy_end", 32'(busy), 0);
    check("z_out_end", 32'(out), 0);

    // Saturation with BASELINE=100, then pile-up on a saturated accumulator.
    sat_trig = 1'b1;
    sat_amp  = 14'd16383;
    step();
    sat_trig = 1'b0;
    check("sat_r1", 32'(sat_out), 4195);
    step();
    check("sat_r2", 32'(sat_out), 8291);
    step();
    check("sat_r3", 32'(sat_out), 12387);
    step();
    check("sat_r4", 32'(sat_out), 16383);
    step();
    check("sat_d1", 32'(sat_out), 15459);
    sat_trig = 1'b1;
    step();
    sat_trig = 1'b0;
    check("sat_pu1", 32'(sat_out), 16383);
    step();
    check("sat_pu2", 32'(sat_out), 16383);
    step();
    step();
    check("sat_pu4", 32'(sat_out), 16383);
    step();
    check("sat_pu_d1", 32'(sat_out), 15459);
    for (int i = 0; i < 400 && sat_busy; i++) step();
    check("sat_idle_busy", 32'(sat_busy), 0);
    check("sat_idle_out", 32'(sat_out), 100);
    check("sat_count", 32'(sat_pcount), 2);

    // Reset asserted mid-decay.
    trig = 1'b1;
    amp  = 14'd1000;
    step();
    trig = 1'b0;
    for (int i = 0; i < 11; i++) step();
    check("mr_busy_before", 32'(busy), 1);
    check("mr_count_before", 32'(pcount), 6);
    #2 reset = 1'b0;
    #1;
    check("mr_out", 32'(out), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_ready", 32'(trig_ready), 0);
    check("mr_count", 32'(pcount), 0);
    #2 reset = 1'b1;
    step();
    check("mr_rel_out", 32'(out), 0);
    check("mr_rel_busy", 32'(busy), 0);
    check("mr_rel_ready", 32'(trig_ready), 1);
    check("mr_rel_count", 32'(pcount), 0);

    // Trigger held high: one acceptance every 2^RISE_SHIFT cycles.
    trig = 1'b1;
    amp  = 14'd1;
    for (int i = 0; i < 80; i++) step();
    trig = 1'b0;
    check("cnt_20", 32'(pcount), 20);
    for (int i = 0; i < 50 && busy; i++) step();
    check("cnt_idle", 32'(busy), 0);
    check("cnt_out", 32'(out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
